// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the decode-stage hazard controller.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned NUM_REGS_DEFAULT = 32;
  localparam int unsigned REG_IDX_W        = 5;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 never set.
module hazard_scoreboard
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  input  logic [REG_IDX_W-1:0] rd_idx,
  output logic                 rs1_pend,
  output logic                 rs2_pend,
  output logic                 rd_pend
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // Next pending vector: clear first so a same-register set wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_en && (clr_idx != '0)) pending_d[clr_idx] = 1'b0;
    if (set_en && (set_idx != '0)) pending_d[set_idx] = 1'b1;
  end

  // Pending register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // Combinational lookups on the registered bits (no WB bypass).
  always_comb begin
    rs1_pend = pending_q[rs1_idx];
    rs2_pend = pending_q[rs2_idx];
    rd_pend  = pending_q[rd_idx];
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage sequencer: issue/stall/squash decisions, memory freeze, stall counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic                 id_reg_write,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 ex_branch_taken,
  input  logic                 mem_busy,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 bubble_ex,
  output logic                 flush_id,
  output logic                 issue,
  output logic                 freeze,
  output logic [CNT_W-1:0]     stall_count
);

  hazard_state_t    state_q, state_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             rs1_pend, rs2_pend, rd_pend;
  logic             hazard;

  hazard_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (reset),
    .set_en   (issue && id_reg_write),
    .set_idx  (id_rd),
    .clr_en   (wb_valid),
    .clr_idx  (wb_rd),
    .rs1_idx  (id_rs1),
    .rs2_idx  (id_rs2),
    .rd_idx   (id_rd),
    .rs1_pend (rs1_pend),
    .rs2_pend (rs2_pend),
    .rd_pend  (rd_pend)
  );

  // RAW on either source or WAW on the destination against in-flight writers.
  always_comb begin
    hazard = id_valid && ((rs1_pend && id_use_rs1) ||
                          (rs2_pend && id_use_rs2) ||
                          (rd_pend  && id_reg_write));
  end

  // Next-state and control outputs.
  // RUN and MEM_WAIT share one branch: MEM_WAIT with mem_busy low is evaluated as RUN.
  always_comb begin
    state_d   = state_q;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    issue     = 1'b0;
    freeze    = 1'b0;
    unique case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_busy) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          if (state_q == MEM_WAIT) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
          end
        end else begin
          state_d = RUN;
          if (ex_branch_taken) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
          end else if (hazard) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
          end else begin
            issue = id_valid;
          end
        end
      end
      default: begin
        stall_if  = 1'b1;
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
        state_d   = RUN;
      end
    endcase
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_id && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= INIT;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
